// File: rtl/seg_display_arbiter_pkg.sv
// Shared types and width helpers for the seven-segment display arbiter.
package disp_arb_pkg;

  typedef enum logic [1:0] {IDLE, SHOW, BLANK} arb_state_t;

  function automatic int id_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int timer_width(input int dwell, input int gap);
    int m;
    m = (dwell > gap) ? dwell : gap;
    return $clog2(m) + 1;
  endfunction

endpackage

// File: rtl/seg_display_arbiter_if.sv
// Requester/display bundle: master = requester side, slave = arbiter side.
interface seg_display_arbiter_if #(parameter int N_REQ = 4);
  import disp_arb_pkg::*;

  localparam int IDW = id_width(N_REQ);

  logic [N_REQ-1:0]       req;
  logic [N_REQ-1:0][15:0] data_in;
  logic [15:0]            disp_data;
  logic                   disp_blank;
  logic [N_REQ-1:0]       grant;
  logic [IDW-1:0]         owner_id;

  modport master (output req, data_in,
                  input  disp_data, disp_blank, grant, owner_id);
  modport slave  (input  req, data_in,
                  output disp_data, disp_blank, grant, owner_id);
endinterface

// File: rtl/seg_display_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request scanning from ptr upward, wrapping.
module rr_pick
  import disp_arb_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int IDW   = 2
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IDW-1:0]   ptr,
  output logic             any,
  output logic [IDW-1:0]   sel
);

  localparam logic [IDW:0] NR = (IDW+1)'(N_REQ);

  logic [2*N_REQ-1:0] dbl;
  logic [N_REQ-1:0]   rot;
  logic [IDW:0]       sum;

  assign dbl = {req, req};
  assign rot = N_REQ'(dbl >> ptr);

  // Descending scan so the lowest rotated position (closest to ptr) wins.
  always_comb begin
    any = 1'b0;
    sel = '0;
    sum = '0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (rot[i]) begin
        any = 1'b1;
        sum = {1'b0, ptr} + (IDW+1)'(i);
        if (sum >= NR) sum = sum - NR;
        sel = sum[IDW-1:0];
      end
    end
  end

endmodule

// File: rtl/seg_display_arbiter.sv
// Round-robin owner of the 4-digit display with minimum dwell and a blank gap between owners.
// Grant rises one cycle after pick, disp_data tracks owner data with one cycle lag; no backpressure.
module seg_display_arbiter
  import disp_arb_pkg::*;
#(
  parameter int          N_REQ        = 4,
  parameter int          DWELL        = 50_000_000,
  parameter int          BLANK_CYCLES = 5_000_000,
  parameter logic [15:0] IDLE_VALUE   = 16'h0000
) (
  input logic                  clk,
  input logic                  rst,
  seg_display_arbiter_if.slave bus
);

  localparam int IDW = id_width(N_REQ);
  localparam int TW  = timer_width(DWELL, BLANK_CYCLES);

  localparam logic [TW-1:0]  DWELL_LAST = TW'(DWELL - 1);
  localparam logic [TW-1:0]  BLANK_LAST = TW'(BLANK_CYCLES - 1);
  localparam logic [IDW-1:0] LAST_ID    = IDW'(N_REQ - 1);

  arb_state_t       state;
  logic [TW-1:0]    timer;
  logic [IDW-1:0]   ptr;
  logic [IDW-1:0]   owner;
  logic [N_REQ-1:0] grant_q;
  logic [15:0]      data_q;
  logic             blank_q;

  logic             pick_any;
  logic [IDW-1:0]   pick_sel;
  logic             owner_req;
  logic             others;
  logic             dwell_done;
  logic             leave;

  rr_pick #(.N_REQ(N_REQ), .IDW(IDW)) u_pick (
    .req (bus.req),
    .ptr (ptr),
    .any (pick_any),
    .sel (pick_sel)
  );

  assign owner_req  = bus.req[owner];
  assign others     = |(bus.req & ~grant_q);
  assign dwell_done = (timer == DWELL_LAST);
  // Early release and dwell preemption collapse into one exit.
  assign leave      = !owner_req || (dwell_done && others);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      timer   <= '0;
      ptr     <= '0;
      owner   <= '0;
      grant_q <= '0;
      data_q  <= IDLE_VALUE;
      blank_q <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          if (pick_any) begin
            state   <= SHOW;
            grant_q <= N_REQ'(1) << pick_sel;
            owner   <= pick_sel;
            blank_q <= 1'b0;
            timer   <= '0;
          end
        end
        SHOW: begin
          if (leave) begin
            state   <= BLANK;
            grant_q <= '0;
            blank_q <= 1'b1;
            data_q  <= IDLE_VALUE;
            ptr     <= (owner == LAST_ID) ? '0 : owner + 1'b1;
            timer   <= '0;
          end else begin
            data_q <= bus.data_in[owner];
            if (!dwell_done) timer <= timer + 1'b1;
          end
        end
        BLANK: begin
          if (timer == BLANK_LAST) begin
            timer <= '0;
            if (pick_any) begin
              state   <= SHOW;
              grant_q <= N_REQ'(1) << pick_sel;
              owner   <= pick_sel;
              blank_q <= 1'b0;
            end else begin
              state <= IDLE;
            end
          end else begin
            timer <= timer + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.grant      = grant_q;
  assign bus.owner_id   = owner;
  assign bus.disp_data  = data_q;
  assign bus.disp_blank = blank_q;

endmodule
